// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, error codes
// and the microsecond-to-cycle conversion used to size the timeout counter loads.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_START  = 2'b01;
  localparam logic [1:0] ERR_PACKET = 2'b10;
  localparam logic [1:0] ERR_NOACK  = 2'b11;

  localparam int TMR_W = 21;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS2_CLK / PS2_DATA pins plus a one-cycle
// strobe on each falling edge of the synchronized clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Flops reset to the idle (pulled-up) bus level so no spurious fall appears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_pin};
      data_ff  <= {data_ff[0], data_pin};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];
  assign fall   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, open-collector OEs).
// Define PS2_HOST_TX_RETRY_EN to retry once after a missing ACK or packet timeout.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ       = 100_000_000,
  parameter int unsigned INHIBIT_US        = 100,
  parameter int unsigned START_TIMEOUT_US  = 15000,
  parameter int unsigned PACKET_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  import ps2_pkg::*;

  localparam logic [TMR_W-1:0] INHIBIT_LOAD =
    TMR_W'(us_to_cycles(CLK_FREQ_HZ, INHIBIT_US) - 1);
  localparam logic [TMR_W-1:0] START_LOAD =
    TMR_W'(us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US) - 1);
  localparam logic [TMR_W-1:0] PACKET_LOAD =
    TMR_W'(us_to_cycles(CLK_FREQ_HZ, PACKET_TIMEOUT_US) - 1);

  ps2_state_t       state, state_next;
  logic             clk_s, data_s, fall;
  logic [TMR_W-1:0] tmr;
  logic             tmr_zero;
  logic [3:0]       bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic             accept;
  logic             fail;
  logic [1:0]       fail_code;
  logic             err_set;
  logic             done_set;
`ifdef PS2_HOST_TX_RETRY_EN
  logic             retried;
  logic             retry_take;
`endif

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_pin  (ps2_clk_in),
    .data_pin (ps2_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .fall     (fall)
  );

  assign tmr_zero = (tmr == '0);
  assign accept   = (state == ST_IDLE) && tx_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Timeout is checked before the fall strobe so expiry wins a same-cycle tie.
  always_comb begin
    state_next = state;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    done_set   = 1'b0;
    err_set    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_take = 1'b0;
`endif
    case (state)
      ST_IDLE:    if (tx_valid) state_next = ST_INHIBIT;
      ST_INHIBIT: if (tmr_zero) state_next = ST_REQ;
      ST_REQ: begin
        if (tmr_zero) begin
          fail      = 1'b1;
          fail_code = ERR_START;
        end else if (fall) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tmr_zero) begin
          fail      = 1'b1;
          fail_code = ERR_PACKET;
        end else if (fall && bit_cnt == 4'd9) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tmr_zero) begin
          fail      = 1'b1;
          fail_code = ERR_PACKET;
        end else if (fall) begin
          if (data_s) begin
            fail      = 1'b1;
            fail_code = ERR_NOACK;
          end else begin
            state_next = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (clk_s && data_s) begin
          state_next = ST_IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
      if (!retried && fail_code != ERR_START) begin
        retry_take = 1'b1;
        state_next = ST_INHIBIT;
      end else begin
        err_set    = 1'b1;
        state_next = ST_IDLE;
      end
`else
      err_set    = 1'b1;
      state_next = ST_IDLE;
`endif
    end
  end

  // ACK entry keeps counting: the packet timeout spans both SHIFT and ACK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr      <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      done <= done_set;
      err  <= err_set;
      if (accept)       err_code <= ERR_NONE;
      else if (err_set) err_code <= fail_code;

      if (state_next == ST_INHIBIT && state != ST_INHIBIT)    tmr <= INHIBIT_LOAD;
      else if (state_next == ST_REQ && state != ST_REQ)       tmr <= START_LOAD;
      else if (state_next == ST_SHIFT && state != ST_SHIFT)   tmr <= PACKET_LOAD;
      else if (!tmr_zero)                                     tmr <= tmr - TMR_W'(1);

      if (state_next == ST_INHIBIT)
        bit_cnt <= '0;
      else if (fall && (state == ST_REQ || state == ST_SHIFT) &&
               (state_next == ST_SHIFT || state_next == ST_ACK))
        bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      byte_q   <= tx_data;
      parity_q <= ~^tx_data;
    end
  end

`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)          retried <= 1'b0;
    else if (accept)     retried <= 1'b0;
    else if (retry_take) retried <= 1'b1;
  end
`endif

  // Counter values 1..8 map to byte bits 0..7; value 8 wraps to index 7.
  assign bit_idx = bit_cnt[2:0] - 3'd1;

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      ST_INHIBIT: ps2_clk_oe  = 1'b1;
      ST_REQ:     ps2_data_oe = 1'b1;
      ST_SHIFT: begin
        if (bit_cnt <= 4'd8)      ps2_data_oe = ~byte_q[bit_idx];
        else if (bit_cnt == 4'd9) ps2_data_oe = ~parity_q;
      end
      default: ;
    endcase
  end

  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// a frame model derived from the byte-plus-odd-parity rule predicts the bits.
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int          INH      = 100;
  localparam int          START_C  = 3000;
  localparam int          HALF     = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, err;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int total = 0;
  int bad = 0;

  int         n_inh = 0, n_done = 0, n_err = 0, inh_run = 0, last_inh_len = 0;
  logic [1:0] last_err_code = 2'b00;
  logic [1:0] err_oes = 2'b00;
  logic       req_data = 1'b0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ       (CLK_HZ),
    .INHIBIT_US        (INH),
    .START_TIMEOUT_US  (START_C),
    .PACKET_TIMEOUT_US (2000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Bus monitor: inhibit run lengths, done/err pulse counts.
  initial begin
    forever begin
      @(negedge clk);
      if (ps2_clk_oe) inh_run++;
      else if (inh_run != 0) begin
        last_inh_len = inh_run;
        n_inh++;
        req_data = ps2_data_oe;
        inh_run = 0;
      end
      if (done) n_done++;
      if (err) begin
        n_err++;
        last_err_code = err_code;
        err_oes = {ps2_clk_oe, ps2_data_oe};
      end
    end
  end

  // Frame as the device sees it: 8 data bits LSB first, odd parity, stop = 1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if (ps2_clk_oe !== 1'b1 || tx_ready !== 1'b0)
      $display("FAIL accept: clk_oe=%b tx_ready=%b want clk_oe=1 tx_ready=0", ps2_clk_oe, tx_ready);
    if (ps2_clk_oe !== 1'b1 || tx_ready !== 1'b0) bad++;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * INH + 50; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL req_wait: got no request-to-send want REQ within %0d cycles", 2 * INH + 50);
    end
  endtask

  task automatic dev_pulse(output logic s);
    @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    s = ps2_data_line;
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic dev_frame(input bit ack, output logic [9:0] got);
    logic s;
    repeat (20) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      dev_pulse(s);
      got[n] = s;
    end
    dev_data_low = ack;
    repeat (10) @(negedge clk);
    dev_pulse(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: tx_ready=%b busy=%b want 1 0", tx_ready, busy);
    end
    total++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      bad++;
      $display("FAIL reset_oe: clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe);
    end
    total++;
    if (done !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
      bad++;
      $display("FAIL reset_status: done=%b err=%b code=%b want 0 0 00", done, err, err_code);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_send(input logic [7:0] b);
    logic [9:0] got, exp;
    int n_done0, n_err0, k;
    bit ok;
    exp = model_frame(b);
    n_done0 = n_done;
    n_err0 = n_err;
    send_byte(b);
    wait_req(ok);
    if (!ok) return;
    @(negedge clk);
    total++;
    if (last_inh_len !== INH) begin
      bad++;
      $display("FAIL inhibit_len: got %0d want %0d", last_inh_len, INH);
    end
    total++;
    if (req_data !== 1'b1) begin
      bad++;
      $display("FAIL start_bit: data_oe at clk release %b want 1", req_data);
    end
    dev_frame(1'b1, got);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL frame_%h: got %b want %b", b, got, exp);
    end
    @(negedge clk);
    dev_data_low = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != 3) begin
      bad++;
      $display("FAIL done_latency: got %0d want 3", k);
    end
    repeat (3) @(negedge clk);
    total++;
    if (n_done - n_done0 != 1 || n_err != n_err0) begin
      bad++;
      $display("FAIL done_count: done=%0d err=%0d want 1 0", n_done - n_done0, n_err - n_err0);
    end
  endtask

  task automatic test_start_timeout();
    int k;
    bit ok;
    send_byte(8'h5A);
    wait_req(ok);
    if (!ok) return;
    k = 0;
    while (!err && k < START_C + 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != START_C) begin
      bad++;
      $display("FAIL start_timeout_cycles: got %0d want %0d", k, START_C);
    end
    total++;
    if (err_code !== 2'b01) begin
      bad++;
      $display("FAIL start_timeout_code: got %b want 01", err_code);
    end
    total++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_timeout_release: clk_oe=%b data_oe=%b ready=%b want 0 0 1",
               ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_ack();
    logic [9:0] got;
    int n_err0, n_done0, n_inh0, exp_inh;
    bit ok;
    n_err0 = n_err;
    n_done0 = n_done;
    n_inh0 = n_inh;
    send_byte(8'hF4);
    wait_req(ok);
    if (!ok) return;
    dev_frame(1'b0, got);
`ifdef PS2_HOST_TX_RETRY_EN
    exp_inh = 2;
    total++;
    if (n_err != n_err0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL retry_hold: err pulses=%0d busy=%b want 0 1", n_err - n_err0, busy);
    end
    wait_req(ok);
    if (!ok) return;
    dev_frame(1'b0, got);
`else
    exp_inh = 1;
`endif
    repeat (5) @(negedge clk);
    total++;
    if (n_err - n_err0 != 1 || last_err_code !== 2'b11) begin
      bad++;
      $display("FAIL noack_err: pulses=%0d code=%b want 1 11", n_err - n_err0, last_err_code);
    end
    total++;
    if (err_oes !== 2'b00 || n_done != n_done0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL noack_release: oes=%b done=%0d ready=%b want 00 0 1",
               err_oes, n_done - n_done0, tx_ready);
    end
    total++;
    if (n_inh - n_inh0 != exp_inh) begin
      bad++;
      $display("FAIL noack_inhibits: got %0d want %0d", n_inh - n_inh0, exp_inh);
    end
    total++;
    if (err_code !== 2'b11) begin
      bad++;
      $display("FAIL noack_code_held: got %b want 11", err_code);
    end
  endtask

  task automatic test_reset_mid();
    logic s;
    int n_err0, n_done0;
    bit ok;
    n_err0 = n_err;
    n_done0 = n_done;
    send_byte(8'hF4);
    wait_req(ok);
    if (!ok) return;
    repeat (20) @(negedge clk);
    for (int n = 0; n < 3; n++) dev_pulse(s);
    @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_release: clk_oe=%b data_oe=%b ready=%b want 0 0 1",
               ps2_clk_oe, ps2_data_oe, tx_ready);
    end
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
    total++;
    if (n_err != n_err0 || n_done != n_done0) begin
      bad++;
      $display("FAIL midreset_pulses: err=%0d done=%0d want 0 0", n_err - n_err0, n_done - n_done0);
    end
    test_send(8'hF4);
  endtask

  task automatic test_busy_back_to_back();
    logic [9:0] got;
    int k, n_inh0;
    bit ok, ready_bad;
    n_inh0 = n_inh;
    send_byte(8'hF4);
    ready_bad = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'hAA;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0 || busy !== 1'b1) ready_bad = 1'b1;
    end
    tx_valid = 1'b0;
    total++;
    if (ready_bad) begin
      bad++;
      $display("FAIL busy_flags: tx_ready/busy changed while busy, want ready=0 busy=1");
    end
    wait_req(ok);
    if (!ok) return;
    @(negedge clk);
    total++;
    if (last_inh_len !== INH) begin
      bad++;
      $display("FAIL busy_inhibit_len: got %0d want %0d", last_inh_len, INH);
    end
    dev_frame(1'b1, got);
    total++;
    if (got !== model_frame(8'hF4)) begin
      bad++;
      $display("FAIL busy_frame: got %b want %b", got, model_frame(8'hF4));
    end
    @(negedge clk);
    dev_data_low = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL busy_done: got %b want 1", done);
    end
    test_send(8'($urandom_range(0, 255)));
    total++;
    if (n_inh - n_inh0 != 2) begin
      bad++;
      $display("FAIL b2b_inhibits: got %0d want 2", n_inh - n_inh0);
    end
  endtask

  initial begin
    test_reset();
    test_send(8'hF4);
    test_send(8'hFF);
    for (int i = 0; i < 3; i++) test_send(8'($urandom_range(0, 255)));
    test_start_timeout();
    test_no_ack();
    test_reset_mid();
    test_busy_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
